fir_coeff_loader: RTL and testbench

FIR_COEFF_LOADER -- requirements
Module: fir_coeff_loader

---
 rtl/fir_coeff_loader.sv | 146 ++++++++++++++
 tb/tb_fir_coeff_loader.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/fir_coeff_loader.sv
// FIR coefficient loader: turns software register strobes into shadow-bank RAM writes
// and applies bank swaps on FIR frame boundaries. Optional checksum: FIR_COEFF_CHECKSUM_EN.
module fir_coeff_loader #(
    parameter int AW = 8,
    parameter int CW = 16
) (
    input  logic          user_clk,
    input  logic          user_rst_n,
    input  logic [31:0]   reg_data,
    input  logic          sync_in,
    output logic          coeff_we,
    output logic [AW:0]   coeff_addr,
    output logic [CW-1:0] coeff_data,
    output logic          bank_sel,
    output logic          swap_pending,
    output logic [AW:0]   load_count,
    output logic [31:0]   coeff_sum
);

    // state     | meaning
    // IDLE      | no write in flight, no swap pending
    // WRITE     | coeff_we asserted this cycle
    // SWAP_WAIT | swap requested, waiting for sync_in outside WRITE
    typedef enum logic [1:0] {IDLE, WRITE, SWAP_WAIT} state_t;

    state_t          state_q, state_d;
    logic            wr_strb_q, sw_strb_q;
    logic [AW:0]     coeff_addr_q, coeff_addr_d;
    logic [CW-1:0]   coeff_data_q, coeff_data_d;
    logic            bank_sel_q, bank_sel_d;
    logic            swap_pending_q, swap_pending_d;
    logic [AW:0]     load_count_q, load_count_d;
    logic            wr_req, sw_req, swap_apply;
    logic            unused_reg;

    assign unused_reg = ^reg_data;

    assign wr_req     = reg_data[31] & ~wr_strb_q;
    assign sw_req     = reg_data[30] & ~sw_strb_q;
    // A swap never lands on the cycle a write is being issued.
    assign swap_apply = sync_in & swap_pending_q & (state_q != WRITE);

    always_comb begin
        state_d        = state_q;
        coeff_addr_d   = coeff_addr_q;
        coeff_data_d   = coeff_data_q;
        bank_sel_d     = bank_sel_q;
        swap_pending_d = swap_pending_q;
        load_count_d   = load_count_q;

        if (wr_req) begin
            coeff_addr_d = {~bank_sel_q, reg_data[16 +: AW]};
            coeff_data_d = reg_data[CW-1:0];
        end

        if ((state_q == WRITE) && (load_count_q != '1))
            load_count_d = load_count_q + {{AW{1'b0}}, 1'b1};

        if (swap_apply) begin
            bank_sel_d     = ~bank_sel_q;
            swap_pending_d = 1'b0;
            load_count_d   = '0;
        end

        // A fresh swap edge is never lost, even if an older swap is applied now.
        if (sw_req)
            swap_pending_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (wr_req)
                    state_d = WRITE;
                else if (swap_pending_d)
                    state_d = SWAP_WAIT;
            end
            WRITE: begin
                if (wr_req)
                    state_d = WRITE;
                else if (swap_pending_d)
                    state_d = SWAP_WAIT;
                else
                    state_d = IDLE;
            end
            SWAP_WAIT: begin
                if (wr_req)
                    state_d = WRITE;
                else if (!swap_pending_d)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            state_q        <= IDLE;
            wr_strb_q      <= 1'b1;
            sw_strb_q      <= 1'b1;
            coeff_addr_q   <= '0;
            coeff_data_q   <= '0;
            bank_sel_q     <= 1'b0;
            swap_pending_q <= 1'b0;
            load_count_q   <= '0;
        end else begin
            state_q        <= state_d;
            wr_strb_q      <= reg_data[31];
            sw_strb_q      <= reg_data[30];
            coeff_addr_q   <= coeff_addr_d;
            coeff_data_q   <= coeff_data_d;
            bank_sel_q     <= bank_sel_d;
            swap_pending_q <= swap_pending_d;
            load_count_q   <= load_count_d;
        end
    end

`ifdef FIR_COEFF_CHECKSUM_EN
    logic [31:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (swap_apply)
            sum_d = '0;
        else if (state_q == WRITE)
            sum_d = sum_q + 32'(coeff_data_q);
    end

    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n)
            sum_q <= '0;
        else
            sum_q <= sum_d;
    end

    assign coeff_sum = sum_q;
`else
    assign coeff_sum = '0;
`endif

    assign coeff_we     = (state_q == WRITE);
    assign coeff_addr   = coeff_addr_q;
    assign coeff_data   = coeff_data_q;
    assign bank_sel     = bank_sel_q;
    assign swap_pending = swap_pending_q;
    assign load_count   = load_count_q;

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Directed bench for fir_coeff_loader: default instance (AW=8) plus an AW=1 instance for saturation.
module tb_fir_coeff_loader;

`ifdef FIR_COEFF_CHECKSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    logic        user_clk = 1'b0;
    logic        user_rst_n;
    logic [31:0] reg_data;
    logic        sync_in;
    logic        coeff_we;
    logic [8:0]  coeff_addr;
    logic [15:0] coeff_data;
    logic        bank_sel;
    logic        swap_pending;
    logic [8:0]  load_count;
    logic [31:0] coeff_sum;

    logic [31:0] reg_data_s;
    logic        coeff_we_s;
    logic [1:0]  coeff_addr_s;
    logic [15:0] coeff_data_s;
    logic        bank_sel_s;
    logic        swap_pending_s;
    logic [1:0]  load_count_s;
    logic [31:0] coeff_sum_s;

    int n_checks = 0;
    int n_err    = 0;

    always #5 user_clk = ~user_clk;

    fir_coeff_loader #(.AW(8), .CW(16)) dut (
        .user_clk     (user_clk),
        .user_rst_n   (user_rst_n),
        .reg_data     (reg_data),
        .sync_in      (sync_in),
        .coeff_we     (coeff_we),
        .coeff_addr   (coeff_addr),
        .coeff_data   (coeff_data),
        .bank_sel     (bank_sel),
        .swap_pending (swap_pending),
        .load_count   (load_count),
        .coeff_sum    (coeff_sum)
    );

    fir_coeff_loader #(.AW(1), .CW(16)) u_sat (
        .user_clk     (user_clk),
        .user_rst_n   (user_rst_n),
        .reg_data     (reg_data_s),
        .sync_in      (1'b0),
        .coeff_we     (coeff_we_s),
        .coeff_addr   (coeff_addr_s),
        .coeff_data   (coeff_data_s),
        .bank_sel     (bank_sel_s),
        .swap_pending (swap_pending_s),
        .load_count   (load_count_s),
        .coeff_sum    (coeff_sum_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge user_clk);
        #1;
    endtask

    task automatic do_reset();
        user_rst_n = 1'b0;
        #2;
        @(negedge user_clk);
        user_rst_n = 1'b1;
    endtask

    function automatic logic [31:0] exp_sum(input logic [31:0] v);
        return CSUM ? v : 32'h0;
    endfunction

    initial begin
        user_rst_n = 1'b0;
        reg_data   = 32'h0;
        reg_data_s = 32'h0;
        sync_in    = 1'b0;
        #2;
        chk("rst_we",      32'(coeff_we),     32'h0);
        chk("rst_addr",    32'(coeff_addr),   32'h0);
        chk("rst_data",    32'(coeff_data),   32'h0);
        chk("rst_bank",    32'(bank_sel),     32'h0);
        chk("rst_pending", 32'(swap_pending), 32'h0);
        chk("rst_load",    32'(load_count),   32'h0);
        chk("rst_sum",     coeff_sum,         32'h0);
        @(negedge user_clk);
        user_rst_n = 1'b1;

        // Basic write
        reg_data = 32'h0000_1234; step();
        reg_data = 32'h8005_1234; step();
        chk("wr_we",   32'(coeff_we),   32'h1);
        chk("wr_addr", 32'(coeff_addr), 32'h105);
        chk("wr_data", 32'(coeff_data), 32'h1234);
        chk("wr_load_before", 32'(load_count), 32'h0);
        step();
        chk("wr_we_off", 32'(coeff_we),   32'h0);
        chk("wr_load",   32'(load_count), 32'h1);
        reg_data = 32'h0003_5678; step();
        chk("hold_addr", 32'(coeff_addr), 32'h105);
        chk("hold_data", 32'(coeff_data), 32'h1234);
        chk("wr_sum",    coeff_sum,       exp_sum(32'h1234));

        // Swap after a write, applied by a later sync_in
        reg_data = 32'h0; do_reset(); step();
        reg_data = 32'h8002_0011; step();
        chk("sw_wr_addr", 32'(coeff_addr), 32'h102);
        reg_data = 32'h4000_0000; step();
        chk("sw_load_pre", 32'(load_count),   32'h1);
        chk("sw_pending",  32'(swap_pending), 32'h1);
        repeat (4) step();
        chk("sw_wait_bank",    32'(bank_sel),     32'h0);
        chk("sw_wait_pending", 32'(swap_pending), 32'h1);
        sync_in = 1'b1; step(); sync_in = 1'b0;
        chk("sw_bank",    32'(bank_sel),     32'h1);
        chk("sw_cleared", 32'(swap_pending), 32'h0);
        chk("sw_load",    32'(load_count),   32'h0);
        chk("sw_sum",     coeff_sum,         32'h0);
        reg_data = 32'h8007_00AA; step();
        chk("sw_next_we",   32'(coeff_we),   32'h1);
        chk("sw_next_addr", 32'(coeff_addr), 32'h007);
        step();
        chk("sw_next_load", 32'(load_count), 32'h1);
        chk("sw_next_sum",  coeff_sum,       exp_sum(32'h00AA));

        // Simultaneous strobes with sync_in, then sync_in during WRITE
        reg_data = 32'h0; do_reset(); step();
        reg_data = 32'hC003_00FF; sync_in = 1'b1; step();
        chk("sim_we",      32'(coeff_we),     32'h1);
        chk("sim_addr",    32'(coeff_addr),   32'h103);
        chk("sim_data",    32'(coeff_data),   32'h00FF);
        chk("sim_bank",    32'(bank_sel),     32'h0);
        chk("sim_pending", 32'(swap_pending), 32'h1);
        step();
        chk("defer_bank",    32'(bank_sel),     32'h0);
        chk("defer_pending", 32'(swap_pending), 32'h1);
        chk("defer_load",    32'(load_count),   32'h1);
        sync_in = 1'b0; step();
        chk("defer_bank2", 32'(bank_sel), 32'h0);
        sync_in = 1'b1; step(); sync_in = 1'b0;
        chk("sim_swap_bank",    32'(bank_sel),     32'h1);
        chk("sim_swap_pending", 32'(swap_pending), 32'h0);
        chk("sim_swap_load",    32'(load_count),   32'h0);

        // Strobe held through reset release
        reg_data = 32'h8001_0001; do_reset();
        for (int i = 0; i < 3; i++) begin
            step();
            chk("held_no_we", 32'(coeff_we), 32'h0);
        end
        reg_data = 32'h0001_0001; step();
        reg_data = 32'h8001_0001; step();
        chk("held_we",   32'(coeff_we),   32'h1);
        chk("held_addr", 32'(coeff_addr), 32'h101);
        step();
        chk("held_we_off", 32'(coeff_we), 32'h0);
        step();
        chk("held_we_off2", 32'(coeff_we),   32'h0);
        chk("held_load",    32'(load_count), 32'h1);

        // Reset in the middle of a write
        reg_data = 32'h0002_0002; step();
        reg_data = 32'h8002_0002; step();
        chk("abort_we_pre", 32'(coeff_we), 32'h1);
        user_rst_n = 1'b0; #1;
        chk("abort_we",   32'(coeff_we),   32'h0);
        chk("abort_load", 32'(load_count), 32'h0);
        @(negedge user_clk); user_rst_n = 1'b1;
        step(); step();
        chk("abort_we_post",   32'(coeff_we),   32'h0);
        chk("abort_load_post", 32'(load_count), 32'h0);

        // Checksum over back-to-back writes, cleared on swap
        reg_data = 32'h0; step();
        reg_data = 32'h8000_FFFF; step();
        chk("cs_we0",   32'(coeff_we),   32'h1);
        chk("cs_data0", 32'(coeff_data), 32'hFFFF);
        reg_data = 32'h0; step();
        reg_data = 32'h8000_0001; step();
        chk("cs_we1", 32'(coeff_we), 32'h1);
        reg_data = 32'h0; step();
        reg_data = 32'h8000_0010; step();
        chk("cs_we2", 32'(coeff_we), 32'h1);
        reg_data = 32'h0; step();
        chk("cs_load", 32'(load_count), 32'h3);
        chk("cs_sum",  coeff_sum,       exp_sum(32'h0001_0010));
        reg_data = 32'h4000_0000; step();
        sync_in = 1'b1; step(); sync_in = 1'b0;
        chk("cs_sum_swap",  coeff_sum,       32'h0);
        chk("cs_load_swap", 32'(load_count), 32'h0);

        // Saturation on the AW=1 instance
        for (int i = 0; i < 5; i++) begin
            reg_data_s = 32'h8001_0003; step();
            chk("sat_we",   32'(coeff_we_s),   32'h1);
            chk("sat_addr", 32'(coeff_addr_s), 32'h3);
            reg_data_s = 32'h0; step();
            if (i == 2) chk("sat_load3", 32'(load_count_s), 32'h3);
        end
        chk("sat_load5", 32'(load_count_s), 32'h3);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
